// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED mode scheduler.
package led_sched_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      BLANK = 1'b1
   } state_t;

   // Advance one pattern, wrapping the last mode back to 0.
   function automatic int unsigned next_mode(
      input int unsigned cur,
      input int unsigned num
   );
      return (cur == num - 1) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debounces a synchronized button level and flags its rising edges.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise_pulse
);

   localparam int unsigned CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   // A level is accepted only after it differs for DEBOUNCE_CYCLES in a row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         if (din == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt        <= '0;
            level      <= din;
            rise_pulse <= din;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_mode_scheduler.sv
// Selects the LED pattern from button steps and timed auto-advance,
// blanking the LEDs briefly after every change.
module led_mode_scheduler
   import led_sched_pkg::*;
#(
   parameter int unsigned NUM_MODES       = 5,
   parameter int unsigned MODE_W          = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned DWELL_CYCLES    = 300000000,
   parameter int unsigned BLANK_CYCLES    = 10000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_next,
   input  logic              auto_en,
   output logic [MODE_W-1:0] mode,
   output logic              blank,
   output logic              mode_change
);

   localparam int unsigned DWW =
      (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int unsigned BW =
      (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_CYCLES - 1);
   localparam logic [BW-1:0] BLANK_LAST =
      BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   logic btn_meta, btn_s;
   logic auto_meta, auto_s;
   logic stable, press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta  <= 1'b0;
         btn_s     <= 1'b0;
         auto_meta <= 1'b0;
         auto_s    <= 1'b0;
      end else begin
         btn_meta  <= btn_next;
         btn_s     <= btn_meta;
         auto_meta <= auto_en;
         auto_s    <= auto_meta;
      end
   end

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .din       (btn_s),
      .level     (stable),
      .rise_pulse(press)
   );

   state_t            state, state_n;
   logic [MODE_W-1:0] mode_n;
   logic              blank_n, change_n;
   logic [DWW-1:0]    dwell, dwell_n;
   logic [BW-1:0]     blank_cnt, blank_cnt_n;
   logic              expire, advance;

   assign expire  = auto_s && (dwell == DWELL_LAST);
   assign advance = press || expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         mode        <= '0;
         blank       <= 1'b0;
         mode_change <= 1'b0;
         dwell       <= '0;
         blank_cnt   <= '0;
      end else begin
         state       <= state_n;
         mode        <= mode_n;
         blank       <= blank_n;
         mode_change <= change_n;
         dwell       <= dwell_n;
         blank_cnt   <= blank_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      mode_n      = mode;
      blank_n     = blank;
      change_n    = 1'b0;
      dwell_n     = dwell;
      blank_cnt_n = blank_cnt;
      unique case (state)
         RUN: begin
            if (advance) begin
               mode_n   = MODE_W'(next_mode(32'(mode), NUM_MODES));
               change_n = 1'b1;
               dwell_n  = '0;
               if (BLANK_CYCLES > 0) begin
                  state_n     = BLANK;
                  blank_n     = 1'b1;
                  blank_cnt_n = '0;
               end
            end else if (auto_s) begin
               dwell_n = dwell + 1'b1;
            end else begin
               dwell_n = '0;
            end
         end
         // Presses arriving here are dropped; dwell stays parked at 0.
         BLANK: begin
            dwell_n = '0;
            if (blank_cnt == BLANK_LAST) begin
               state_n     = RUN;
               blank_n     = 1'b0;
               blank_cnt_n = '0;
            end else begin
               blank_cnt_n = blank_cnt + 1'b1;
            end
         end
         default: begin
            state_n = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed and random checks of led_mode_scheduler against a countdown model.
module tb_led_mode_scheduler;

   localparam int NM = 5;
   localparam int DB = 4;
   localparam int DW = 20;
   localparam int BL = 3;
   localparam int MW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          btn_next;
   logic          auto_en;
   logic [MW-1:0] mode;
   logic          blank;
   logic          mode_change;

   int total = 0;
   int bad = 0;
   int chg_seen = 0;

   int m_s1, m_s2, m_a1, m_a2;
   int m_stable, m_run, m_press;
   int m_mode, m_left, m_dwell, m_chg;

   always #5 clk = ~clk;

   led_mode_scheduler #(
      .NUM_MODES      (NM),
      .MODE_W         (MW),
      .DEBOUNCE_CYCLES(DB),
      .DWELL_CYCLES   (DW),
      .BLANK_CYCLES   (BL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_next   (btn_next),
      .auto_en    (auto_en),
      .mode       (mode),
      .blank      (blank),
      .mode_change(mode_change)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_a1 = 0; m_a2 = 0;
      m_stable = 0; m_run = 0; m_press = 0;
      m_mode = 0; m_left = 0; m_dwell = 0; m_chg = 0;
   endtask

   // One clock edge of the reference: blanking is a countdown of
   // remaining cycles, debounce a run length of disagreeing samples.
   task automatic model_edge(input int b, input int a);
      int p;
      p = m_press;
      m_chg = 0;
      if (m_left > 0) begin
         m_left--;
         m_dwell = 0;
      end else if (p != 0 || (m_a2 != 0 && m_dwell == DW - 1)) begin
         m_mode = (m_mode + 1) % NM;
         m_chg = 1;
         m_left = BL;
         m_dwell = 0;
      end else begin
         m_dwell = (m_a2 != 0) ? m_dwell + 1 : 0;
      end
      m_press = 0;
      m_run = (m_s2 != m_stable) ? m_run + 1 : 0;
      if (m_run == DB) begin
         m_stable = m_s2;
         m_run = 0;
         m_press = m_s2;
      end
      m_s2 = m_s1; m_s1 = b;
      m_a2 = m_a1; m_a1 = a;
   endtask

   task automatic step(input logic b, input logic a);
      btn_next = b;
      auto_en = a;
      @(posedge clk);
      model_edge(int'(b), int'(a));
      @(negedge clk);
      chk("mode", 32'(mode), m_mode);
      chk("blank", 32'(blank), (m_left > 0) ? 1 : 0);
      chk("chg", 32'(mode_change), m_chg);
      if (mode_change) chg_seen++;
   endtask

   task automatic do_reset(input logic a);
      rst = 1'b1;
      btn_next = 1'b0;
      auto_en = a;
      repeat (3) @(negedge clk);
      model_reset();
      chk("rst_mode", 32'(mode), 0);
      chk("rst_blank", 32'(blank), 0);
      chk("rst_chg", 32'(mode_change), 0);
      rst = 1'b0;
   endtask

   task automatic wait_chg(input logic b, input logic a, input int limit,
                           output int n);
      n = 0;
      do begin
         step(b, a);
         n++;
      end while (!mode_change && n < limit);
      chk("chg_wait", 32'(mode_change), 1);
   endtask

   initial begin
      int n, nb, first, len;
      logic a, b;
      logic [MW-1:0] mid;

      do_reset(1'b0);
      chg_seen = 0;
      repeat (100) step(1'b0, 1'b0);
      chk("idle_chg", chg_seen, 0);
      chk("idle_mode", 32'(mode), 0);

      // Five clean presses: 7-cycle latency, 3 blank cycles, wrap to 0.
      for (int i = 0; i < 5; i++) begin
         chg_seen = 0;
         wait_chg(1'b1, 1'b0, 20, n);
         chk("press_lat", n, 7);
         chk("press_mode", 32'(mode), (i + 1) % NM);
         nb = int'(blank);
         for (int k = 0; k < 15; k++) begin
            step(k < 3, 1'b0);
            nb += int'(blank);
         end
         chk("press_blank_len", nb, BL);
         chk("press_once", chg_seen, 1);
      end

      chg_seen = 0;
      for (int k = 0; k < 12; k++) step(((k / 2) % 2) == 0, 1'b0);
      repeat (10) step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);
      chk("bounce_once", chg_seen, 1);
      chk("bounce_mode", 32'(mode), 1);

      chg_seen = 0;
      repeat (3) step(1'b1, 1'b0);
      repeat (15) step(1'b0, 1'b0);
      chk("glitch_none", chg_seen, 0);

      // Auto-advance from reset: 22 cycles, then every 23.
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) begin
         wait_chg(1'b0, 1'b1, 40, n);
         chk("auto_gap", n, (i == 0) ? 22 : 23);
         chk("auto_mode", 32'(mode), (i + 1) % NM);
      end

      chg_seen = 0;
      for (int k = 1; k <= 22; k++) step(1'b0, k <= 17);
      chk("auto_drop_none", chg_seen, 0);
      wait_chg(1'b0, 1'b1, 40, n);
      chk("auto_resync", n, 22);
      chk("auto_resync_mode", 32'(mode), 1);

      // Press lands on the expire edge: one increment only.
      chg_seen = 0;
      first = 0;
      mid = '0;
      for (int k = 1; k <= 46; k++) begin
         step(k >= 17 && k < 27, 1'b1);
         if (mode_change && first == 0) begin
            first = k;
            mid = mode;
         end
      end
      chk("coin_at", first, 23);
      chk("coin_mode", 32'(mid), 2);
      chk("coin_chgs", chg_seen, 2);

      // Press lands inside blanking: dropped.
      chg_seen = 0;
      first = 0;
      for (int k = 1; k <= 46; k++) begin
         step(k >= 19 && k < 29, 1'b1);
         if (mode_change && first == 0) first = k;
         if (k == 30) mid = mode;
      end
      chk("blankpress_at", first, 23);
      chk("blankpress_mode", 32'(mid), 4);
      chk("blankpress_chgs", chg_seen, 2);
      chk("blankpress_wrap", 32'(mode), 0);

      // Reset in the middle of blanking with mode 3.
      do_reset(1'b0);
      for (int i = 0; i < 2; i++) begin
         repeat (10) step(1'b1, 1'b0);
         repeat (12) step(1'b0, 1'b0);
      end
      wait_chg(1'b1, 1'b0, 20, n);
      chk("pre_rst_mode", 32'(mode), 3);
      chk("pre_rst_blank", 32'(blank), 1);
      rst = 1'b1;
      btn_next = 1'b0;
      #1;
      chk("rst_blank_mode", 32'(mode), 0);
      chk("rst_blank_blank", 32'(blank), 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chg_seen = 0;
      repeat (40) step(1'b0, 1'b0);
      chk("post_rst_none", chg_seen, 0);

      // Random button levels and auto toggles against the model.
      a = 1'($urandom_range(0, 1));
      do_reset(a);
      n = 0;
      while (n < 800) begin
         b = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 8);
         repeat (len) step(b, a);
         n += len;
         if ($urandom_range(0, 15) == 0) a = ~a;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
